// File: rtl/div_pkg.sv
// Shared types and constants for the sequenced restoring divider.
package div_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int QUOT_LSB  = 0;
  localparam int REM_LSB   = DEF_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift a dividend bit into the partial remainder and conditionally subtract.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Partial remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits
  // and the borrow out of the extra bit is an exact "shifted < divisor" indicator.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_bit_o = ~diff[WIDTH];
    rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock behind valid/ready handshakes.
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               dbz,
  output logic               busy
);

  localparam int CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int REM_OFS = (WIDTH == DEF_WIDTH) ? REM_LSB : QUOT_LSB + WIDTH;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   step_rem;
  logic               step_bit;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[WIDTH-1]),
    .divisor_i (div_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  // The dividend register doubles as the quotient: it shifts left and each new bit enters at the LSB.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          div_d = B;
          if (B == '0) begin
            state_d = DONE;
            dbz_d   = 1'b1;
            dvd_d   = '1;
            rem_d   = A;
          end else begin
            state_d = CALC;
            dvd_d   = A;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH - 1);
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        dvd_d = (dvd_q << 1) | WIDTH'(step_bit);
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          dbz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    result                    = '0;
    result[QUOT_LSB +: WIDTH] = dvd_q;
    result[REM_OFS +: WIDTH]  = rem_q;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign dbz       = dbz_q;

endmodule
